// File: rtl/nx_fifo_wr_rr_arb_if.sv
// Requester-side bundle for nx_fifo_wr_rr_arb: per-requester valid/last/data in, one-hot ready out.
// master = producers (drive valid/last/data), slave = arbiter (drives ready).
interface nx_fifo_wr_rr_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 71
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_last,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_last,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/nx_fifo_wr_rr_arb.sv
// Round-robin write arbiter in front of a shared 1R1W FIFO; halts on overflow/ECC until halt_clr.
// Ports: clk, rst (sync, active-high), req (slave bundle), fifo_wen/fifo_wdata (registered write),
// fifo_free_slots/fifo_overflow/fifo_ecc_err (FIFO status), halt_clr/halted, grant_id, beat_cnt.
// Optional: define NX_FIFO_ARB_LOCK_EN to hold the grant until the last beat of a packet.
module nx_fifo_wr_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 71,
    parameter int SLOT_W  = 12,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    nx_fifo_wr_rr_arb_if.slave  req,
    output logic                fifo_wen,
    output logic [DATA_W-1:0]   fifo_wdata,
    input  logic [SLOT_W-1:0]   fifo_free_slots,
    input  logic                fifo_overflow,
    input  logic                fifo_ecc_err,
    input  logic                halt_clr,
    output logic                halted,
    output logic [ID_W-1:0]     grant_id,
    output logic [15:0]         beat_cnt
);
    typedef enum logic {RUN, HALT} state_t;

    state_t             state;
    logic [ID_W-1:0]    last_id;
    logic [SLOT_W:0]    space;
    logic               space_ok;
    logic               err;
    logic               sel_vld;
    logic [ID_W-1:0]    sel_id;
    logic               grant_en;
    logic [NUM_REQ-1:0] ready_w;
    logic [DATA_W-1:0]  sel_data;

`ifdef NX_FIFO_ARB_LOCK_EN
    logic               lock_vld;
    logic [ID_W-1:0]    lock_id;
`else
    logic               unused_last;
    assign unused_last = ^req.req_last;
`endif

    // The registered write is not yet reflected in free_slots; the extra
    // top bit catches a borrow so a stale count can never look positive.
    assign space    = {1'b0, fifo_free_slots} - {{SLOT_W{1'b0}}, fifo_wen};
    assign space_ok = !space[SLOT_W] && (space != '0);
    assign err      = fifo_overflow || fifo_ecc_err;

    always_comb begin
        int idx;
        idx     = 0;
        sel_vld = 1'b0;
        sel_id  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_id) + k) % NUM_REQ;
            if (!sel_vld && req.req_valid[idx]) begin
                sel_vld = 1'b1;
                sel_id  = ID_W'(idx);
            end
        end
`ifdef NX_FIFO_ARB_LOCK_EN
        // A held lock pins the grant even if its owner drops valid.
        if (lock_vld) begin
            sel_vld = req.req_valid[lock_id];
            sel_id  = lock_id;
        end
`endif
    end

    assign grant_en = !rst && (state == RUN) && space_ok && sel_vld;
    assign sel_data = req.req_data[sel_id*DATA_W +: DATA_W];

    always_comb begin
        ready_w = '0;
        if (grant_en) begin
            ready_w[sel_id] = 1'b1;
        end
    end

    assign req.req_ready = ready_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            halted     <= 1'b0;
            fifo_wen   <= 1'b0;
            fifo_wdata <= '0;
            grant_id   <= '0;
            last_id    <= ID_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            fifo_wen <= grant_en;
            if (grant_en) begin
                fifo_wdata <= sel_data;
                grant_id   <= sel_id;
                last_id    <= sel_id;
            end
            if (halt_clr) begin
                beat_cnt <= '0;
            end else if (grant_en && (beat_cnt != 16'hFFFF)) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
            unique case (state)
                RUN: begin
                    if (err) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                HALT: begin
                    if (halt_clr && !err) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef NX_FIFO_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld <= 1'b0;
            lock_id  <= '0;
        end else if (grant_en) begin
            lock_vld <= !req.req_last[sel_id];
            lock_id  <= sel_id;
        end
    end
`endif
endmodule
